serial_pattern_detector: RTL and testbench
==========================================

# serial_pattern_detector

Serial-input pattern detector that sits directly downstream of the single-bit enable/reset D flip-flop stage. It accepts that stage's serial bit stream, one bit per enabled clock edge, into a WIDTH-bit history window built from the same enable-gated flop behaviour. It flags every occurrence of a fixed bit pattern, overlaps included, and keeps a saturating count of matches. It is the first multi-bit consumer of the flop stage in the datapath.

## Interface
- WIDTH, 4: pattern length and window size in bits; minimum 2.
- PATTERN, 4'b1011: pattern to detect. The MSB is the oldest bit.
- CNT_W, 4: width of the match counter.

- Clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- en  in  1  sample enable; D is accepted only on edges where en=1.
- clr  in  1  synchronous clear of window, fill state, match and count; takes priority over en.
- D  in  1  serial data bit.
- window  out  WIDTH  last WIDTH accepted bits; newest bit in the LSB.
- valid  out  1  high once WIDTH bits have been accepted since the last reset or clr.
- match  out  1  one-cycle registered pulse when the window completes PATTERN.
- match_count  out  CNT_W  number of matches, saturating at 2^CNT_W-1.

## Operation
- Reset values: window=0, valid=0, match=0, match_count=0, fill state EMPTY.
- Accepting edge (en=1, clr=0): window <= {window[WIDTH-2:0], D}.
- Fill FSM, with a fill counter of width clog2(WIDTH+1):
  - EMPTY goes to FILLING on the first accepting edge.
  - FILLING counts accepted bits and goes to FULL on the edge that accepts bit WIDTH.
  - FULL is held until reset or clr.
  - valid = (state==FULL).
- match <= 1 on an accepting edge when the next window equals PATTERN and the next fill count reaches WIDTH. It is 0 on every other edge, including non-accepting edges. A match therefore never fires on a partially filled window, even when the zero-padded window equals PATTERN.
- Overlap is allowed: the window is never flushed after a match.
- match_count increments on the same edge that sets match, and holds at its all-ones value.
- en=0 with clr=0: window, state and count hold; match returns to 0.
- clr=1: all outputs and the FSM return to reset values on that edge, regardless of en or D.
- Reset asserted mid-stream: immediate clear. Refilling requires WIDTH new accepted bits.

## Timing
- Latency: match, window, valid and match_count all update on the same rising edge that accepts the completing bit, i.e. one edge after D is presented.
- D and en must be stable around the rising edge of Clk.
- reset deassertion must be synchronous to Clk at system level; this block does not synchronise it.
- Back-to-back matches are possible only when PATTERN is self-overlapping. For 1011, the minimum spacing is 3 accepted bits.

## Structure
- Shared package serial_pattern_pkg:
  - enum fill_state_t {EMPTY, FILLING, FULL};
  - default constants DEF_WIDTH=4, DEF_PATTERN=4'b1011.
- Sub-module shift_window: the WIDTH-bit enable-gated shift register with async active-low reset and sync clear. It is instantiated once.
- The top level holds the fill FSM, the compare logic and the saturating counter.

## Test plan
- Reset: hold reset=0 while toggling D and en. Require window=0, valid=0, match=0 and match_count=0 throughout.
- Single match: with en=1, shift 1,0,1,1. After the 4th edge require window=4'b1011, valid=1, match=1 for exactly one cycle and match_count=1. After the 3rd edge require valid=0.
- Overlap: with en=1, shift the stream 1,0,1,1,0,1,1. Require match pulses after edges 4 and 7 and match_count=2.
- Enable hold: shift 1,0,1, then drop en for 2 edges with D=1, then raise en and shift 1.
  - While en=0, window holds 4'b0101 and match=0.
  - The final edge gives window=4'b1011, match=1, match_count=1.
- Mid-stream clear and reset:
  - Shift 1,0,1 and pulse reset low for 2 ns between edges. Require an immediate clear to all zeros.
  - Then shift 1 alone. Require no match, valid=0 and fill count 1.
  - Repeat the sequence using clr together with en=1. Require the clear on that edge, with the clr-edge bit discarded.
- Saturation: with CNT_W=2, feed 5 non-overlapping 1011 patterns. Require match_count to read 1, 2, 3, 3, 3, with match still pulsing each time.

Source files
------------

// File: rtl/serial_pattern_detector_pkg.sv
// Shared types and default constants for the serial pattern detector.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } fill_state_t;

  localparam int unsigned DEF_WIDTH = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_PATTERN = 4'b1011;
  localparam int unsigned DEF_CNT_W = 4;

endpackage

// File: rtl/serial_pattern_detector_if.sv
// Serial data in, window/match status out; master drives the bit stream.
interface serial_pattern_detector_if
  import serial_pattern_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             en;
  logic             clr;
  logic             D;
  logic [WIDTH-1:0] window;
  logic             valid;
  logic             match;
  logic [CNT_W-1:0] match_count;

  modport master (
    output en, clr, D,
    input  window, valid, match, match_count
  );

  modport slave (
    input  en, clr, D,
    output window, valid, match, match_count
  );

endinterface

// File: rtl/serial_pattern_detector_shift_window.sv
// Enable-gated WIDTH-bit shift register; newest bit enters at the LSB.
module shift_window #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], d};
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// Detects PATTERN in a serial stream (overlaps allowed) once the window is full,
// with a registered match pulse and a saturating match counter.
module serial_pattern_detector
  import serial_pattern_pkg::*;
#(
  parameter int unsigned          WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0]     PATTERN = DEF_PATTERN,
  parameter int unsigned          CNT_W   = DEF_CNT_W
) (
  input  logic                      Clk,
  input  logic                      reset,
  serial_pattern_detector_if.slave  bus
);

  localparam int unsigned FC_W = $clog2(WIDTH + 1);
  localparam logic [FC_W-1:0] FULL_CNT = FC_W'(WIDTH);

  fill_state_t      state, state_nxt;
  logic [FC_W-1:0]  fcnt, fcnt_nxt;
  logic [WIDTH-1:0] window;
  logic [WIDTH-1:0] win_nxt;
  logic             accept;
  logic             hit;
  logic             match_q;
  logic [CNT_W-1:0] count_q;

  shift_window #(
    .WIDTH (WIDTH)
  ) u_window (
    .clk   (Clk),
    .rst_n (reset),
    .en    (bus.en),
    .clr   (bus.clr),
    .d     (bus.D),
    .q     (window)
  );

  assign accept  = bus.en & ~bus.clr;
  assign win_nxt = {window[WIDTH-2:0], bus.D};

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    hit       = 1'b0;
    if (accept) begin
      case (state)
        EMPTY: begin
          state_nxt = FILLING;
          fcnt_nxt  = fcnt + FC_W'(1);
        end
        FILLING: begin
          fcnt_nxt = fcnt + FC_W'(1);
          if (fcnt_nxt == FULL_CNT) state_nxt = FULL;
        end
        default: ;
      endcase
      // Gating on the fill count keeps a zero-padded partial window from matching.
      hit = (fcnt_nxt == FULL_CNT) && (win_nxt == PATTERN);
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      fcnt    <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else if (bus.clr) begin
      state   <= EMPTY;
      fcnt    <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= state_nxt;
      fcnt    <= fcnt_nxt;
      match_q <= hit;
      if (hit && (count_q != '1)) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.window      = window;
  assign bus.valid       = (state == FULL);
  assign bus.match       = match_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: a bit-history model checked every cycle
// against two instances (4-bit and 2-bit counters), plus hand-computed spot checks.
module tb_serial_pattern_detector;

  localparam logic [3:0] PAT = 4'b1011;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic D = 1'b0;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  always #5 Clk = ~Clk;

  serial_pattern_detector_if #(.WIDTH(4), .CNT_W(4)) bus4 ();
  serial_pattern_detector_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

  assign bus4.en  = en;
  assign bus4.clr = clr;
  assign bus4.D   = D;
  assign bus2.en  = en;
  assign bus2.clr = clr;
  assign bus2.D   = D;

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(4)) dut4 (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // Model: the list of bits accepted since the last clear.
  bit          hist[$];
  logic        m_match = 1'b0;
  int unsigned m_cnt4 = 0;
  int unsigned m_cnt2 = 0;

  function automatic logic [3:0] m_window();
    logic [3:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      if (hist.size() > i) w[i] = hist[hist.size() - 1 - i];
    return w;
  endfunction

  function automatic logic m_valid();
    return hist.size() >= 4;
  endfunction

  task automatic model_clear();
    hist.delete();
    m_match = 1'b0;
    m_cnt4  = 0;
    m_cnt2  = 0;
  endtask

  task automatic model_step(input logic e, input logic c, input logic d);
    if (!reset || c) begin
      model_clear();
    end else if (e) begin
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
      m_match = m_valid() && (m_window() == PAT);
      if (m_match) begin
        if (m_cnt4 < 15) m_cnt4++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end else begin
      m_match = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_on) begin
      check("window4", 32'(bus4.window), 32'(m_window()));
      check("valid4", 32'(bus4.valid), 32'(m_valid()));
      check("match4", 32'(bus4.match), 32'(m_match));
      check("count4", 32'(bus4.match_count), m_cnt4);
      check("window2", 32'(bus2.window), 32'(m_window()));
      check("valid2", 32'(bus2.valid), 32'(m_valid()));
      check("match2", 32'(bus2.match), 32'(m_match));
      check("count2", 32'(bus2.match_count), m_cnt2);
    end
  end

  task automatic tick(input logic e, input logic c, input logic d);
    @(negedge Clk);
    en = e; clr = c; D = d;
    @(posedge Clk);
    model_step(e, c, d);
    #1;
  endtask

  task automatic expect4(input string name, input logic [3:0] w, input logic v,
                         input logic m, input logic [3:0] n);
    check({name, ".window"}, 32'(bus4.window), 32'(w));
    check({name, ".valid"}, 32'(bus4.valid), 32'(v));
    check({name, ".match"}, 32'(bus4.match), 32'(m));
    check({name, ".count"}, 32'(bus4.match_count), 32'(n));
  endtask

  task automatic shift_bits(input logic [6:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) tick(1'b1, 1'b0, bits[i]);
  endtask

  initial begin
    int exp_sat[5] = '{1, 2, 3, 3, 3};
    cmp_on = 1'b1;

    // Reset held low while inputs toggle.
    for (int i = 0; i < 5; i++) begin
      tick(1'(i % 2), 1'b0, 1'(i / 2));
      expect4("reset_hold", 4'b0000, 1'b0, 1'b0, 4'd0);
    end
    reset = 1'b1;

    // Single match.
    shift_bits(7'b101, 3);
    check("single.valid_after3", 32'(bus4.valid), 32'd0);
    tick(1'b1, 1'b0, 1'b1);
    expect4("single", 4'b1011, 1'b1, 1'b1, 4'd1);
    tick(1'b0, 1'b0, 1'b0);
    expect4("single_after", 4'b1011, 1'b1, 1'b0, 4'd1);
    tick(1'b1, 1'b1, 1'b1);
    expect4("clr", 4'b0000, 1'b0, 1'b0, 4'd0);

    // Overlap: 1,0,1,1,0,1,1 -> pulses after edges 4 and 7.
    begin
      logic [6:0] s;
      s = 7'b1011011;
      for (int i = 1; i <= 7; i++) begin
        tick(1'b1, 1'b0, s[7 - i]);
        check($sformatf("overlap.match%0d", i), 32'(bus4.match), 32'((i == 4) || (i == 7)));
      end
      check("overlap.count", 32'(bus4.match_count), 32'd2);
    end
    tick(1'b0, 1'b1, 1'b0);

    // Enable hold.
    shift_bits(7'b101, 3);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      expect4("en_hold", 4'b0101, 1'b0, 1'b0, 4'd0);
    end
    tick(1'b1, 1'b0, 1'b1);
    expect4("en_resume", 4'b1011, 1'b1, 1'b1, 4'd1);

    // Mid-stream async reset.
    tick(1'b0, 1'b1, 1'b0);
    shift_bits(7'b101, 3);
    #1 reset = 1'b0;
    model_clear();
    #1 expect4("async_reset", 4'b0000, 1'b0, 1'b0, 4'd0);
    #1 reset = 1'b1;
    tick(1'b1, 1'b0, 1'b1);
    expect4("after_reset", 4'b0001, 1'b0, 1'b0, 4'd0);
    shift_bits(7'b011, 3);
    expect4("refill", 4'b1011, 1'b1, 1'b1, 4'd1);

    // Mid-stream clr with en=1: clr-edge bit discarded.
    tick(1'b0, 1'b1, 1'b0);
    shift_bits(7'b101, 3);
    tick(1'b1, 1'b1, 1'b1);
    expect4("clr_mid", 4'b0000, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 1'b1);
    expect4("after_clr", 4'b0001, 1'b0, 1'b0, 4'd0);

    // Saturation on the 2-bit counter instance.
    tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      shift_bits(7'b1011, 4);
      check($sformatf("sat.match%0d", k), 32'(bus2.match), 32'd1);
      check($sformatf("sat.count%0d", k), 32'(bus2.match_count), 32'(exp_sat[k]));
    end
    check("sat.count4", 32'(bus4.match_count), 32'd5);

    tick(1'b0, 1'b0, 1'b0);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
